// File: rtl/set_assoc_icache.sv
// N-way set-associative instruction cache with pipelined line refill,
// tree pseudo-LRU replacement, deferred flush and bus-error reporting.
module set_assoc_icache #(
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 8
) (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic        ReqValid,
    input  logic [31:0] ReqAddress,
    output logic        ReqReady,
    output logic        RespValid,
    output logic [31:0] Instruction,
    output logic        RespError,
    input  logic        Flush,
    output logic        BusCycle,
    output logic        BusStrobe,
    output logic        BusReadWrite,
    output logic [31:0] BusAddress,
    input  logic        BusAcknowledge,
    input  logic        BusError,
    input  logic        BusStall,
    input  logic [31:0] BusDataIn
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;

    state_t             state_q, state_d;

    // Storage arrays: data and tags carry no reset, only valid bits and PLRU do.
    logic [31:0]        data_q  [WAYS][SETS*LINE_WORDS];
    logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
    logic [SETS-1:0]    valid_q [WAYS];
    logic [2:0]         plru_q  [SETS];

    // Latched miss request and refill bookkeeping.
    logic [TAG_W-1:0]   tag_r_q;
    logic [IDX_W-1:0]   idx_r_q;
    logic [OFF_W-1:0]   off_r_q;
    logic [WAY_W-1:0]   victim_q;
    logic [OFF_W:0]     issue_q;
    logic [OFF_W-1:0]   ack_q;
    logic               flush_pend_q;
    logic               resp_vld_q;
    logic               resp_err_q;
    logic [31:0]        instr_q;

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [OFF_W-1:0]   req_off;
    logic               hit;
    logic               hit_now;
    logic [WAY_W-1:0]   hit_way;
    logic [31:0]        hit_word;
    logic [WAY_W-1:0]   victim;
    logic               accept;
    logic               last_ack;
    logic               unused_addr_bits;

    assign req_tag          = ReqAddress[31:32-TAG_W];
    assign req_idx          = ReqAddress[32-TAG_W-1:OFF_W+2];
    assign req_off          = ReqAddress[OFF_W+1:2];
    assign unused_addr_bits = ^ReqAddress[1:0];

    assign accept       = ReqValid && ReqReady;
    assign hit_now      = hit && !Flush;
    assign last_ack     = (ack_q == OFF_W'(LINE_WORDS - 1));
    assign BusReadWrite = 1'b0;
    assign RespValid    = resp_vld_q;
    assign RespError    = resp_err_q;
    assign Instruction  = instr_q;

    // PLRU bits name the side to evict next; bit 0 is the tree root.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [2:0] p);
        logic [WAY_W-1:0] v;
        v = '0;
        if (WAYS == 2)
            v = WAY_W'(p[0]);
        else if (WAYS == 4)
            v = WAY_W'(p[0] ? (p[2] ? 3 : 2) : (p[1] ? 1 : 0));
        return v;
    endfunction

    // Point every tree node on the path to way w away from it.
    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [WAY_W-1:0] w);
        logic [2:0] n;
        n = p;
        if (WAYS == 2) begin
            n[0] = ~w[0];
        end else if (WAYS == 4) begin
            n[0] = ~w[WAY_W-1];
            if (w[WAY_W-1])
                n[2] = ~w[0];
            else
                n[1] = ~w[0];
        end
        return n;
    endfunction

    // Tag compare across all ways and victim choice for the presented address.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = plru_victim(plru_q[req_idx]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[w][req_idx])
                victim = WAY_W'(w);
        end
        hit_word = data_q[hit_way][{req_idx, req_off}];
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (!ResetN)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic: a miss refills, the last ack or an error ends the refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !hit_now)
                    state_d = REFILL;
            end
            REFILL: begin
                if (BusError)
                    state_d = RESPOND;
                else if (BusAcknowledge && last_ack)
                    state_d = RESPOND;
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and bus outputs decoded from the state and issue counter.
    always_comb begin
        ReqReady   = (state_q == IDLE) && !flush_pend_q;
        BusCycle   = (state_q == REFILL);
        BusStrobe  = (state_q == REFILL) && (issue_q < (OFF_W+1)'(LINE_WORDS));
        BusAddress = '0;
        if (state_q == REFILL)
            BusAddress = {tag_r_q, idx_r_q, issue_q[OFF_W-1:0], 2'b00};
    end

    // Refill counters, pending flush and the registered response.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            issue_q      <= '0;
            ack_q        <= '0;
            flush_pend_q <= 1'b0;
            resp_vld_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            instr_q      <= '0;
        end else begin
            resp_vld_q <= 1'b0;
            resp_err_q <= 1'b0;
            if (state_q == IDLE)
                flush_pend_q <= 1'b0;
            else if (Flush)
                flush_pend_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        issue_q <= '0;
                        ack_q   <= '0;
                        if (hit_now) begin
                            resp_vld_q <= 1'b1;
                            instr_q    <= hit_word;
                        end
                    end
                end
                REFILL: begin
                    if (BusStrobe && !BusStall)
                        issue_q <= issue_q + 1'b1;
                    if (BusError) begin
                        resp_vld_q <= 1'b1;
                        resp_err_q <= 1'b1;
                    end else if (BusAcknowledge) begin
                        ack_q <= ack_q + 1'b1;
                        if (ack_q == off_r_q)
                            instr_q <= BusDataIn;
                        if (last_ack)
                            resp_vld_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture the missing address and its victim way when a request is accepted.
    always_ff @(posedge Clock) begin
        if ((state_q == IDLE) && accept) begin
            tag_r_q  <= req_tag;
            idx_r_q  <= req_idx;
            off_r_q  <= req_off;
            victim_q <= victim;
        end
    end

    // Valid bits and PLRU: flush in IDLE, touch on hit, validate on completed refill.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            for (int w = 0; w < WAYS; w++)
                valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++)
                plru_q[s] <= '0;
        end else if (state_q == IDLE) begin
            if (Flush || flush_pend_q) begin
                for (int w = 0; w < WAYS; w++)
                    valid_q[w] <= '0;
            end else if (accept && hit) begin
                plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
            end
        end else if ((state_q == REFILL) && BusAcknowledge && !BusError && last_ack) begin
            valid_q[victim_q][idx_r_q] <= 1'b1;
            plru_q[idx_r_q]            <= plru_touch(plru_q[idx_r_q], victim_q);
        end
    end

    // Refill beats land in order in the victim way; the tag goes in with the last beat.
    always_ff @(posedge Clock) begin
        if ((state_q == REFILL) && BusAcknowledge && !BusError) begin
            data_q[victim_q][{idx_r_q, ack_q}] <= BusDataIn;
            if (last_ack)
                tag_q[victim_q][idx_r_q] <= tag_r_q;
        end
    end

endmodule

// File: tb/tb_set_assoc_icache.sv
// Directed bench for set_assoc_icache (WAYS=2, SETS=256, LINE_WORDS=8).
// The bus slave returns (address ^ 32'hC0DE_0000) one cycle after each accepted strobe.
module tb_set_assoc_icache;

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic        ReqValid = 1'b0;
    logic [31:0] ReqAddress = '0;
    logic        ReqReady;
    logic        RespValid;
    logic [31:0] Instruction;
    logic        RespError;
    logic        Flush = 1'b0;
    logic        BusCycle;
    logic        BusStrobe;
    logic        BusReadWrite;
    logic [31:0] BusAddress;
    logic        BusAcknowledge = 1'b0;
    logic        BusError = 1'b0;
    logic        BusStall = 1'b0;
    logic [31:0] BusDataIn = '0;

    set_assoc_icache #(.WAYS(2), .SETS(256), .LINE_WORDS(8)) dut (
        .Clock(Clock), .ResetN(ResetN),
        .ReqValid(ReqValid), .ReqAddress(ReqAddress), .ReqReady(ReqReady),
        .RespValid(RespValid), .Instruction(Instruction), .RespError(RespError),
        .Flush(Flush),
        .BusCycle(BusCycle), .BusStrobe(BusStrobe), .BusReadWrite(BusReadWrite),
        .BusAddress(BusAddress), .BusAcknowledge(BusAcknowledge), .BusError(BusError),
        .BusStall(BusStall), .BusDataIn(BusDataIn)
    );

    always #5 Clock = ~Clock;

    localparam logic [31:0] PAT = 32'hC0DE_0000;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] q[$];
    int          strobes, resp_cnt, ack_num, lat, rcyc, stall_cnt;
    int          err_at = -1;
    bit          stall_en = 0;
    bit          rst_done;
    logic        bc_after_rst, rdy_after_rst;
    logic [31:0] last_instr;
    logic        last_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: advance to the falling edge, run the slave, record any response.
    task automatic step();
        logic [31:0] a;
        @(negedge Clock);
        BusAcknowledge = 1'b0;
        BusError       = 1'b0;
        if (BusCycle !== 1'b1) begin
            q.delete();
            BusStall = 1'b0;
            rcyc     = 0;
        end else begin
            if (q.size() > 0) begin
                a = q.pop_front();
                if (ack_num == err_at) begin
                    BusError = 1'b1;
                end else begin
                    BusAcknowledge = 1'b1;
                    BusDataIn      = a ^ PAT;
                end
                ack_num++;
            end
            BusStall = stall_en && (rcyc >= 2) && (rcyc <= 4);
            if (BusStall) begin
                stall_cnt++;
                chk("stall_addr", BusAddress, 32'h0000_1008);
            end
            if (BusStrobe && !BusStall) begin
                q.push_back(BusAddress);
                strobes++;
            end
            rcyc++;
        end
        if (RespValid === 1'b1) begin
            resp_cnt++;
            last_instr = Instruction;
            last_err   = RespError;
        end
    endtask

    // Issue one fetch and follow it to its response (or an injected reset).
    task automatic fetch(input logic [31:0] addr, input int flush_at, input int rst_at);
        int wcyc;
        strobes  = 0;
        resp_cnt = 0;
        ack_num  = 0;
        rst_done = 0;
        ReqValid   = 1'b1;
        ReqAddress = addr;
        wcyc = 0;
        while (!ReqReady && wcyc < 50) begin
            step();
            wcyc++;
        end
        step();
        ReqValid   = 1'b0;
        ReqAddress = 32'hFFFF_FFFC;
        lat = 1;
        while (resp_cnt == 0 && lat < 200 && !rst_done) begin
            Flush = (lat == flush_at);
            if (lat == rst_at) begin
                ResetN = 1'b0;
                step();
                bc_after_rst  = BusCycle;
                rdy_after_rst = ReqReady;
                ResetN   = 1'b1;
                rst_done = 1;
            end else begin
                step();
                lat++;
            end
        end
        Flush = 1'b0;
        step();
        step();
    endtask

    initial begin
        step();
        step();
        chk("rst_ReqReady", ReqReady, 1);
        chk("rst_RespValid", RespValid, 0);
        chk("rst_RespError", RespError, 0);
        chk("rst_BusCycle", BusCycle, 0);
        chk("rst_BusStrobe", BusStrobe, 0);
        chk("rst_BusAddress", BusAddress, 0);
        chk("rst_Instruction", Instruction, 0);
        chk("rst_BusReadWrite", BusReadWrite, 0);
        ResetN = 1'b1;
        step();

        fetch(32'h0000_1004, -1, -1);
        chk("cold_strobes", strobes, 8);
        chk("cold_resp_once", resp_cnt, 1);
        chk("cold_word", last_instr, 32'hC0DE_1004);
        chk("cold_err", last_err, 0);
        chk("cold_ready_after", ReqReady, 1);

        fetch(32'h0000_1008, -1, -1);
        chk("hit_latency", lat, 1);
        chk("hit_strobes", strobes, 0);
        chk("hit_word", last_instr, 32'hC0DE_1008);

        fetch(32'h0000_20A0, -1, -1);
        chk("A_fill_strobes", strobes, 8);
        fetch(32'h0000_40A0, -1, -1);
        chk("B_fill_strobes", strobes, 8);
        fetch(32'h0000_20A0, -1, -1);
        chk("A_touch_strobes", strobes, 0);
        fetch(32'h0000_60A0, -1, -1);
        chk("C_fill_strobes", strobes, 8);
        chk("C_word", last_instr, 32'hC0DE_60A0);
        fetch(32'h0000_20A0, -1, -1);
        chk("A_still_hits", strobes, 0);
        chk("A_word", last_instr, 32'hC0DE_20A0);
        fetch(32'h0000_40A0, -1, -1);
        chk("B_evicted_misses", strobes, 8);

        err_at = 3;
        fetch(32'h0000_2000, -1, -1);
        err_at = -1;
        chk("err_resp_once", resp_cnt, 1);
        chk("err_flag", last_err, 1);
        fetch(32'h0000_2000, -1, -1);
        chk("err_refetch_strobes", strobes, 8);
        chk("err_refetch_flag", last_err, 0);
        chk("err_refetch_word", last_instr, 32'hC0DE_2000);

        fetch(32'h0000_3004, 3, -1);
        chk("flush_resp_once", resp_cnt, 1);
        chk("flush_word", last_instr, 32'hC0DE_3004);
        fetch(32'h0000_3008, -1, -1);
        chk("flush_line_misses", strobes, 8);
        chk("flush_refill_word", last_instr, 32'hC0DE_3008);

        stall_en  = 1;
        stall_cnt = 0;
        fetch(32'h0000_100C, -1, -1);
        stall_en = 0;
        chk("stall_cycles", stall_cnt, 3);
        chk("stall_strobes", strobes, 8);
        chk("stall_word", last_instr, 32'hC0DE_100C);
        for (int i = 0; i < 8; i++) begin
            fetch(32'h0000_1000 + 32'(4 * i), -1, -1);
            chk("stall_slot_hit", strobes, 0);
            chk("stall_slot_word", last_instr, 32'hC0DE_1000 + 32'(4 * i));
        end

        fetch(32'h0000_5000, -1, 4);
        chk("rst_mid_BusCycle", bc_after_rst, 0);
        chk("rst_mid_ReqReady", rdy_after_rst, 1);
        chk("rst_mid_no_resp", resp_cnt, 0);
        fetch(32'h0000_5000, -1, -1);
        chk("rst_line_invalid", strobes, 8);
        chk("rst_refill_word", last_instr, 32'hC0DE_5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
